// File: rtl/fq_pkg.sv
// Shared widths and descriptor types for the fair-queue flow buffer.
package fq_pkg;

    localparam int unsigned COUNT_W         = 32;
    localparam int unsigned DEF_NUM_IN_LOG2 = 3;
    localparam int unsigned DEF_DEPTH_LOG2  = 4;
    localparam int unsigned DEF_LEN_W       = 16;

    typedef logic [DEF_NUM_IN_LOG2-1:0] flow_id_t;
    typedef logic [DEF_LEN_W-1:0]       len_t;
    typedef logic [COUNT_W-1:0]         count_t;

    typedef struct packed {
        flow_id_t flow;
        len_t     len;
    } fq_desc_t;

endpackage

// File: rtl/fq_len_fifo.sv
// Single-flow length FIFO; also exposes the head as it will be after this edge
// so the parent can register its finish tag without an extra cycle.
module fq_len_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [LEN_W-1:0]      i_din,
    output logic [LEN_W-1:0]      o_head,
    output logic [LEN_W-1:0]      o_head_nxt,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [LEN_W-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd;
    logic [DEPTH_LOG2-1:0] r_wr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] w_rd_inc;

    assign w_rd_inc = r_rd + DEPTH_LOG2'(1);
    assign o_empty  = (r_cnt == '0);
    assign o_full   = (r_cnt == CNT_W'(DEPTH));
    assign o_head   = r_mem[r_rd];
    assign o_count  = r_cnt;

    // An empty FIFO, or a sole entry being popped, hands the head to the incoming word.
    always_comb begin
        o_head_nxt = r_mem[r_rd];
        if (o_empty || (i_pop && r_cnt == CNT_W'(1))) begin
            o_head_nxt = i_din;
        end else if (i_pop) begin
            o_head_nxt = r_mem[w_rd_inc];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + DEPTH_LOG2'(1);
            if (i_pop)  r_rd <= w_rd_inc;
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

endmodule

// File: rtl/fq_flow_buf.sv
// Per-flow length buffers with served-byte counters and global virtual time,
// presenting registered finish tags and non-empty flags to the min picker.
module fq_flow_buf
    import fq_pkg::*;
#(
    parameter  int unsigned NUM_IN_LOG2 = DEF_NUM_IN_LOG2,
    parameter  int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter  int unsigned LEN_W       = DEF_LEN_W,
    localparam int unsigned NF          = 2**NUM_IN_LOG2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    input  logic [NUM_IN_LOG2-1:0]      i_in_flow,
    input  logic [LEN_W-1:0]            i_in_len,
    output logic                        o_in_ready,
    output logic [NF-1:0][COUNT_W-1:0]  o_count,
    output logic [NF-1:0]               o_valid,
    input  logic [NUM_IN_LOG2-1:0]      i_pick,
    input  logic                        i_pick_valid,
    output logic                        o_deq_valid,
    output logic [NUM_IN_LOG2-1:0]      o_deq_flow,
    output logic [LEN_W-1:0]            o_deq_len,
    output logic                        o_bad_pick
);

    localparam int unsigned OCC_W = DEPTH_LOG2 + 1;

    logic [NF-1:0]               w_push;
    logic [NF-1:0]               w_pop;
    logic [NF-1:0]               w_empty;
    logic [NF-1:0]               w_full;
    logic [NF-1:0][LEN_W-1:0]    w_head;
    logic [NF-1:0][LEN_W-1:0]    w_head_nxt;
    logic [NF-1:0][OCC_W-1:0]    w_occ;
    logic [NF-1:0][OCC_W-1:0]    w_occ_nxt;
    logic [NF-1:0]               w_valid_nxt;
    logic [NF-1:0][COUNT_W-1:0]  w_served_nxt;
    logic [NF-1:0][COUNT_W-1:0]  w_count_nxt;
    count_t                      w_vtime_nxt;
    logic                        w_deq;
    logic [LEN_W-1:0]            w_pick_len;

    logic [NF-1:0][COUNT_W-1:0]  r_served;
    logic [NF-1:0][COUNT_W-1:0]  r_count;
    logic [NF-1:0]               r_valid;
    count_t                      r_vtime;
    logic                        r_deq_valid;
    logic [NUM_IN_LOG2-1:0]      r_deq_flow;
    logic [LEN_W-1:0]            r_deq_len;
    logic                        r_bad_pick;

    for (genvar g = 0; g < NF; g++) begin : g_fifo
        fq_len_fifo #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .LEN_W      (LEN_W)
        ) u_fifo (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_push     (w_push[g]),
            .i_pop      (w_pop[g]),
            .i_din      (i_in_len),
            .o_head     (w_head[g]),
            .o_head_nxt (w_head_nxt[g]),
            .o_count    (w_occ[g]),
            .o_empty    (w_empty[g]),
            .o_full     (w_full[g])
        );
    end

    assign o_in_ready = !w_full[i_in_flow];
    assign w_deq      = i_pick_valid && r_valid[i_pick];
    assign w_pick_len = w_head[i_pick];

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        w_push[i_in_flow] = i_in_valid && !w_full[i_in_flow];
        w_pop[i_pick]     = w_deq;
        w_vtime_nxt = w_deq ? r_served[i_pick] + COUNT_W'(w_pick_len) : r_vtime;
        // A popped flow's new served value equals the new vtime; an idle flow
        // waking up adopts it too. Popping a flow implies it was not empty.
        for (int unsigned i = 0; i < NF; i++) begin
            w_served_nxt[i] = (w_pop[i] || (w_push[i] && w_empty[i])) ? w_vtime_nxt : r_served[i];
            w_occ_nxt[i]    = w_occ[i] + OCC_W'(w_push[i]) - OCC_W'(w_pop[i]);
            w_valid_nxt[i]  = (w_occ_nxt[i] != '0);
            w_count_nxt[i]  = w_valid_nxt[i] ? w_served_nxt[i] + COUNT_W'(w_head_nxt[i]) : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_served    <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_vtime     <= '0;
            r_deq_valid <= 1'b0;
            r_deq_flow  <= '0;
            r_deq_len   <= '0;
            r_bad_pick  <= 1'b0;
        end else begin
            r_served    <= w_served_nxt;
            r_count     <= w_count_nxt;
            r_valid     <= w_valid_nxt;
            r_vtime     <= w_vtime_nxt;
            r_deq_valid <= w_deq;
            r_bad_pick  <= i_pick_valid && !r_valid[i_pick];
            if (w_deq) begin
                r_deq_flow <= i_pick;
                r_deq_len  <= w_pick_len;
            end
        end
    end

    assign o_count     = r_count;
    assign o_valid     = r_valid;
    assign o_deq_valid = r_deq_valid;
    assign o_deq_flow  = r_deq_flow;
    assign o_deq_len   = r_deq_len;
    assign o_bad_pick  = r_bad_pick;

endmodule

// File: tb/tb_fq_flow_buf.sv
// Bench for fq_flow_buf: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fq_flow_buf;
    import fq_pkg::*;

    localparam int NF    = 8;
    localparam int DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    i_rst;
    logic                    i_in_valid;
    logic [2:0]              i_in_flow;
    logic [15:0]             i_in_len;
    logic                    o_in_ready;
    logic [NF-1:0][31:0]     o_count;
    logic [NF-1:0]           o_valid;
    logic [2:0]              i_pick;
    logic                    i_pick_valid;
    logic                    o_deq_valid;
    logic [2:0]              o_deq_flow;
    logic [15:0]             o_deq_len;
    logic                    o_bad_pick;

    always #5 clk = ~clk;

    fq_flow_buf #(
        .NUM_IN_LOG2 (3),
        .DEPTH_LOG2  (4),
        .LEN_W       (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .i_in_flow    (i_in_flow),
        .i_in_len     (i_in_len),
        .o_in_ready   (o_in_ready),
        .o_count      (o_count),
        .o_valid      (o_valid),
        .i_pick       (i_pick),
        .i_pick_valid (i_pick_valid),
        .o_deq_valid  (o_deq_valid),
        .o_deq_flow   (o_deq_flow),
        .o_deq_len    (o_deq_len),
        .o_bad_pick   (o_bad_pick)
    );

    // Reference model: one queue per flow plus served counters and vtime.
    int unsigned mq [NF][$];
    bit [31:0]   m_served [NF];
    bit [31:0]   m_vtime;
    bit          m_deq_valid;
    int          m_deq_flow;
    int          m_deq_len;
    bit          m_bad;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_count(input int i);
        if (mq[i].size() == 0) return 32'd0;
        return m_served[i] + mq[i][0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NF; i++) begin
            mq[i].delete();
            m_served[i] = 0;
        end
        m_vtime = 0;
        m_deq_valid = 0;
        m_deq_flow = 0;
        m_deq_len = 0;
        m_bad = 0;
    endtask

    task automatic check_all();
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("valid[%0d]", i), o_valid[i], mq[i].size() != 0);
            chk($sformatf("count[%0d]", i), o_count[i], m_count(i));
        end
        chk("deq_valid", o_deq_valid, m_deq_valid);
        chk("bad_pick", o_bad_pick, m_bad);
        if (m_deq_valid) begin
            chk("deq_flow", o_deq_flow, m_deq_flow);
            chk("deq_len", o_deq_len, m_deq_len);
        end
    endtask

    task automatic step(input bit iv, input int fl, input int len,
                        input bit pv, input int pk, input bit do_chk);
        bit          acc;
        bit          deq;
        bit          was_empty;
        int unsigned h;
        i_in_valid   = iv;
        i_in_flow    = fl[2:0];
        i_in_len     = len[15:0];
        i_pick_valid = pv;
        i_pick       = pk[2:0];
        #1;
        if (do_chk) chk("in_ready", o_in_ready, mq[fl].size() < DEPTH);
        @(posedge clk);
        acc       = iv && (mq[fl].size() < DEPTH);
        was_empty = (mq[fl].size() == 0);
        deq       = pv && (mq[pk].size() != 0);
        m_bad       = pv && !deq;
        m_deq_valid = deq;
        if (deq) begin
            h = mq[pk].pop_front();
            m_served[pk] += h;
            m_vtime = m_served[pk];
            m_deq_flow = pk;
            m_deq_len = int'(h);
        end
        if (acc) begin
            if (was_empty) m_served[fl] = m_vtime;
            mq[fl].push_back(len & 32'hFFFF);
        end
        #1;
        if (do_chk) check_all();
    endtask

    // Reset is held for two edges with traffic offered, which must be ignored.
    task automatic do_reset();
        i_rst        = 1'b1;
        i_in_valid   = 1'b1;
        i_in_flow    = 3'd2;
        i_in_len     = 16'd7;
        i_pick_valid = 1'b1;
        i_pick       = 3'd0;
        @(posedge clk);
        m_reset();
        #1;
        chk("rst_in_ready", o_in_ready, 1);
        check_all();
        @(posedge clk);
        #1;
        chk("rst_in_ready2", o_in_ready, 1);
        check_all();
        i_rst        = 1'b0;
        i_in_valid   = 1'b0;
        i_pick_valid = 1'b0;
    endtask

    typedef struct {
        bit       iv;
        fq_desc_t d;
        bit       pv;
        flow_id_t pk;
        flow_id_t cf;
        count_t   cnt;
        bit       cval;
        bit       cdeq;
        len_t     dlen;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int pct;
        i_rst = 1'b1;
        i_in_valid = 1'b0;
        i_in_flow = '0;
        i_in_len = '0;
        i_pick_valid = 1'b0;
        i_pick = '0;
        m_reset();
        do_reset();

        // Directed vectors: basic enqueue, two pops, and a wake-up at vtime 96.
        tbl[0] = '{1'b1, '{3'd2, 16'd100}, 1'b0, 3'd0, 3'd2, 32'd100, 1'b1, 1'b0, 16'd0};
        tbl[1] = '{1'b1, '{3'd0, 16'd64},  1'b0, 3'd0, 3'd0, 32'd64,  1'b1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, '{3'd0, 16'd32},  1'b0, 3'd0, 3'd0, 32'd64,  1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, '{3'd0, 16'd0},   1'b1, 3'd0, 3'd0, 32'd96,  1'b1, 1'b1, 16'd64};
        tbl[4] = '{1'b0, '{3'd0, 16'd0},   1'b1, 3'd0, 3'd0, 32'd0,   1'b0, 1'b1, 16'd32};
        tbl[5] = '{1'b1, '{3'd5, 16'd10},  1'b0, 3'd0, 3'd5, 32'd106, 1'b1, 1'b0, 16'd0};
        for (int r = 0; r < 6; r++) begin
            step(tbl[r].iv, int'(tbl[r].d.flow), int'(tbl[r].d.len),
                 tbl[r].pv, int'(tbl[r].pk), 1'b1);
            chk($sformatf("tbl%0d_valid", r), o_valid[tbl[r].cf], tbl[r].cval);
            chk($sformatf("tbl%0d_count", r), o_count[tbl[r].cf], tbl[r].cnt);
            chk($sformatf("tbl%0d_deq", r), o_deq_valid, tbl[r].cdeq);
            if (tbl[r].cdeq) chk($sformatf("tbl%0d_dlen", r), o_deq_len, tbl[r].dlen);
        end

        // Full flow: back-pressure, no bypass on a same-cycle pop.
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(1, 1, k + 1, 0, 0, 1);
        i_in_valid = 1'b0;
        i_in_flow = 3'd1;
        #1 chk("full_ready_f1", o_in_ready, 0);
        i_in_flow = 3'd3;
        #1 chk("full_ready_f3", o_in_ready, 1);
        step(1, 1, 999, 0, 0, 1);
        step(1, 1, 777, 1, 1, 1);
        chk("full_pop_len", o_deq_len, 1);
        chk("ready_after_pick", o_in_ready, 1);
        chk("count1_after_pick", o_count[1], 3);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 1, 1);
        chk("full_drained", o_valid[1], 0);

        // Same-cycle enqueue and pop on a 1-entry flow.
        do_reset();
        step(1, 4, 20, 0, 0, 1);
        step(1, 4, 40, 1, 4, 1);
        chk("same_deq_len", o_deq_len, 20);
        chk("same_valid4", o_valid[4], 1);
        chk("same_count4", o_count[4], 60);
        step(0, 0, 0, 1, 4, 1);

        // Pick on an empty flow.
        step(0, 0, 0, 1, 7, 1);
        chk("bad_pick_hi", o_bad_pick, 1);
        chk("bad_no_deq", o_deq_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("bad_pick_lo", o_bad_pick, 0);

        // Drive served[6] up to 0xFFFF_FFF0, then wrap.
        do_reset();
        step(1, 6, 'hFFFF, 0, 0, 0);
        for (int k = 0; k < 65535; k++) step(1, 6, 'hFFFF, 1, 6, 0);
        step(1, 6, 'hFFF0, 1, 6, 1);
        step(0, 0, 0, 1, 6, 1);
        step(1, 6, 'h20, 0, 0, 1);
        chk("wrap_count6", o_count[6], 32'h0000_0010);
        step(0, 0, 0, 1, 6, 1);
        chk("wrap_deq_len", o_deq_len, 16'h20);
        step(1, 6, 5, 0, 0, 1);
        chk("wrap_served6", o_count[6], 32'h0000_0015);

        // Reset with descriptors buffered.
        do_reset();
        step(1, 3, 11, 0, 0, 1);
        step(1, 3, 12, 0, 0, 1);
        step(1, 3, 0, 0, 0, 1);
        chk("pre_rst_valid3", o_valid[3], 1);
        do_reset();
        chk("post_rst_valid", o_valid, '0);
        chk("post_rst_count3", o_count[3], 0);
        step(0, 0, 0, 1, 3, 1);
        chk("post_rst_nodeq", o_deq_valid, 0);

        // Randomized traffic: fill-biased phase, then drain-biased phase.
        for (int n = 0; n < 3000; n++) begin
            int fl;
            int len;
            if (n % 700 == 699) begin
                do_reset();
            end else begin
                pct = (n < 1500) ? 30 : 85;
                fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
                case ($urandom_range(0, 5))
                    0:       len = 0;
                    1:       len = 'hFFFF;
                    default: len = int'($urandom_range(1, 'hFFFF));
                endcase
                step($urandom_range(0, 3) != 0, fl, len,
                     $urandom_range(0, 99) < pct, int'($urandom_range(0, 7)), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fq_flow_buf.md
# fq_flow_buf

Per-flow packet-length buffer and virtual-time tracker that sits directly upstream of the fair-queue minimum picker. Accepts packet descriptors (flow id, length), holds them in one FIFO per flow, and presents each flow's finish tag (`count`) and non-empty flag (`valid`) to the picker. Consumes the picker's `pick`: pops that flow's head, advances its served-byte counter and the global virtual time, and emits a one-cycle dequeue strobe.

## Interface
- `NUM_IN_LOG2`, 3: log2 of the flow count; `NF = 2**NUM_IN_LOG2`.
- `DEPTH_LOG2`, 4: log2 of the per-flow FIFO depth.
- `LEN_W`, 16: width of the packet length in bytes.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  descriptor offered.
- `in_flow`  in  NUM_IN_LOG2  target flow.
- `in_len`  in  LEN_W  packet length in bytes.
- `in_ready`  out  1  combinational; equals `!full[in_flow]`.
- `count`  out  32 x NF  per-flow finish tag; registered.
- `valid`  out  1 x NF  per-flow non-empty; registered.
- `pick`  in  NUM_IN_LOG2  flow chosen by the picker.
- `pick_valid`  in  1  `pick` is meaningful this cycle.
- `deq_valid`  out  1  one-cycle dequeue strobe.
- `deq_flow`  out  NUM_IN_LOG2  dequeued flow.
- `deq_len`  out  LEN_W  dequeued length.
- `bad_pick`  out  1  one-cycle pulse when a pick targets an empty flow.

## Operation
- State per flow: FIFO of `2**DEPTH_LOG2` lengths, occupancy counter, `served[i]` (32 b). Global state: `vtime` (32 b).
- Enqueue: fires when `in_valid && in_ready`. The length is pushed to FIFO `in_flow`. If the flow was empty and is not being popped this cycle, `served[in_flow]` is loaded with the post-update `vtime`. This prevents an idle flow from banking credit.
- Dequeue: fires when `pick_valid && valid[pick]`. The head is popped and `served[pick] += head_len`, mod 2^32. `vtime` is loaded with the same new value. Next cycle: `deq_valid=1`, `deq_flow=pick`, `deq_len=head_len`.
- Ignored pick: `pick_valid && !valid[pick]` changes no state and pulses `bad_pick`.
- Tag: `count[i] = served[i] + zero_ext(head_len[i])` mod 2^32 when the flow is non-empty. `count[i] = 0` when it is empty.
- Wrap-around: all 32-bit arithmetic is modulo 2^32. Out-of-order wrap comparison is the picker's responsibility.
- Enqueue and dequeue on the same flow in the same cycle:
  - Both take effect; occupancy is unchanged.
  - A 1-entry flow stays valid, and the new packet becomes the head.
  - `served` is not reloaded from `vtime`.
- Enqueue on a flow while a different flow is popped: an empty target flow takes the new `vtime`, i.e. the popped flow's updated `served`.
- Full: `in_ready=0` for that flow. No pop bypass, even if the same flow is popped that cycle.
- `in_len=0` is legal. It is buffered and dequeued normally, and `served` is unchanged.

## Timing
- Reset values: all FIFOs empty, `served=0`, `vtime=0`, `count=0`, `valid=0`, `deq_valid=0`, `deq_flow=0`, `deq_len=0`, `bad_pick=0`. `in_ready=1` while reset is held.
- Reset mid-operation: all buffered descriptors are discarded on the reset edge. No `deq_valid` is issued for them.
- Enqueue accepted at edge N: `valid`/`count` are updated in the cycle after edge N (latency 1).
- Pick sampled at edge N: `deq_*` is valid and `count`/`valid` reflect the pop in the cycle after edge N. Sustained picks give one dequeue per cycle.
- `in_ready` depends only on registered occupancy and `in_flow`. It has no path from `pick`.

## Structure
- Package `fq_pkg`:
  - `COUNT_W=32` and the default `NUM_IN_LOG2`/`LEN_W`.
  - Typedefs `flow_id_t`, `len_t`, `count_t`.
  - Struct `fq_desc_t` {flow, len}.
- Sub-module `fq_len_fifo`: single-flow synchronous FIFO with push, pop, head, count, empty and full, instantiated NF times. Simultaneous push and pop on a full FIFO is never presented, since the top level blocks it.

## Test plan
- Reset, then enqueue (flow 2, len 100) -> next cycle `valid[2]=1`, `count[2]=100`. All other `valid` stay 0.
- Enqueue flow 0 len 64 and flow 0 len 32; pick 0 twice ->
  - `deq_len` 64 then 32.
  - `count[0]` 64 -> 96 -> 0; `valid[0]=0`; `vtime=96`.
  - Then enqueue flow 5 len 10 -> `count[5]=106`.
- Fill flow 1 with 16 entries -> `in_ready=0` for `in_flow=1` and 1 for `in_flow=3`. A further offer to flow 1 is not accepted. Pick 1 -> `in_ready` rises the next cycle.
- Same-cycle enqueue len 40 and pick on flow 4 holding one len-20 entry -> `deq_len=20`, `valid[4]` stays 1, `count[4]=20+40=60`.
- Preload `served[6]=0xFFFF_FFF0` via repeated traffic; enqueue len 0x20 -> `count[6]=0x0000_0010`. Pick -> `served[6]=0x10`.
- Pick 7 while flow 7 is empty -> `bad_pick` pulses for one cycle, no `deq_valid`, state unchanged. Assert `rst` with 3 entries buffered -> all outputs return to their reset values.
